mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single unified instruction/data memory of the multicycle core.
- Shares the memory between the CPU port (driven by the multicycle controller's fetch/load/store cycles) and a DMA/boot-loader port.
- Round-robin grant; request/acknowledge handshake per port; fixed, parameterised memory read latency.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing the unified instruction/data memory
// between the CPU port and the DMA/boot-loader port; one transaction per LATENCY+3 cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_dma;
  logic             pick_dma;

  // last_dma resets to DMA so the CPU wins the first tie, while grant itself resets to 0.
  assign pick_dma = dma_req && (!cpu_req || !last_dma);
  assign busy     = (state != IDLE);

  // NOTE: every register below is updated with <= so all of them see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dma  <= 1'b1;
      grant     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            grant     <= pick_dma;
            last_dma  <= pick_dma;
            mem_we    <= pick_dma ? dma_we    : cpu_we;
            mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt    <= CNT_W'(LATENCY);
          state  <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          // Read data is valid exactly LATENCY cycles after the strobe, i.e. when cnt reaches 1.
          if (cnt == CNT_W'(1)) begin
            if (!mem_we) begin
              if (grant) dma_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            if (grant) dma_ack <= 1'b1;
            else       cpu_ack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors and corner sequences at LATENCY=1 and 3,
// then randomized two-port traffic checked against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we, busy, grant;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  // LATENCY=3 instance, CPU port only
  logic          b_reset, b_req, b_ack, b_dack;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rdata, b_drdata;
  logic          b_mem_en, b_mem_we, b_busy, b_grant;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(3)) dut3 (
    .clk(clk), .reset(b_reset),
    .cpu_req(b_req), .cpu_we(1'b0), .cpu_addr(b_addr), .cpu_wdata('0),
    .cpu_ack(b_ack), .cpu_rdata(b_rdata),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr('0), .dma_wdata('0),
    .dma_ack(b_dack), .dma_rdata(b_drdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .grant(b_grant)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hC3A5_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory for the LATENCY=1 instance; the bus carries garbage except in the valid cycle.
  logic [DW-1:0] env_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = init_val(i);
    env_mem[8'h10] = 32'hDEADBEEF;
  end
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? env_mem[mem_addr[7:0]] : $urandom;
  end

  // Memory for the LATENCY=3 instance: 0xCAFEF00D only in the cycle three after the strobe.
  logic [1:0] b_sh = 2'b00;
  always @(posedge clk) begin
    b_sh        <= {b_sh[0], b_mem_en};
    b_mem_rdata <= b_sh[1] ? 32'hCAFEF00D : $urandom;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit dma, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (dma) begin
      dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  typedef struct {
    bit            dma;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  // Called at the negedge of an IDLE cycle, which becomes t0.
  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0]    en_mask, ack_mask, other_mask;
    logic [DW-1:0] rd;
    en_mask = '0; ack_mask = '0; other_mask = '0; rd = '0;
    drive(v.dma, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      en_mask[k]    = mem_en;
      ack_mask[k]   = v.dma ? dma_ack : cpu_ack;
      other_mask[k] = v.dma ? cpu_ack : dma_ack;
      if (k == 1) begin
        check($sformatf("vec%0d_mem_addr", idx), 64'(mem_addr), 64'(v.addr));
        check($sformatf("vec%0d_we_grant", idx), 64'({mem_we, grant}), 64'({v.we, v.dma}));
        if (v.we) check($sformatf("vec%0d_mem_wdata", idx), 64'(mem_wdata), 64'(v.wdata));
      end
      if (k == 3) begin
        rd = v.dma ? dma_rdata : cpu_rdata;
        drive(v.dma, 1'b0, 1'b0, '0, '0);
      end
    end
    check($sformatf("vec%0d_en_timing", idx), 64'(en_mask), 64'h02);
    check($sformatf("vec%0d_ack_timing", idx), 64'(ack_mask), 64'h08);
    check($sformatf("vec%0d_other_ack", idx), 64'(other_mask), 64'h00);
    check($sformatf("vec%0d_rdata", idx), 64'(rd), 64'(v.exp_rdata));
  endtask

  vec_t          vecs [5];
  logic [15:0]   en_m, ack_m;
  logic [3:0]    order, gr;
  int            at [4];
  int            n, ack_cyc;
  logic [AW-1:0] en_addr [4];
  logic          noack;

  // Random-phase model state
  bit            pend [2];
  logic          we_r [2];
  logic [AW-1:0] a_r [2];
  logic [DW-1:0] d_r [2];
  logic [DW-1:0] last_rd [2];
  int            age [2];
  logic [DW-1:0] ref_mem [256];
  int            ntx;
  logic          ack_p;
  logic [DW-1:0] rd_p;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678,  32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h10, 32'hA5A5A5A5,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hA5A5A5A5};
    vecs[4] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'h12345678};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    b_req = 1'b0; b_addr = '0;
    reset = 1'b1; b_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({cpu_ack, dma_ack, mem_en, mem_we, busy, grant}), 64'h0);
    check("reset_bus", 64'({mem_addr, mem_wdata}), 64'h0);
    check("reset_rdata", 64'({cpu_rdata, dma_rdata}), 64'h0);
    check("reset_l3_ctrl", 64'({b_ack, b_dack, b_mem_en, b_busy, b_grant}), 64'h0);
    reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Fresh reset, then both ports request continuously: CPU wins the first tie, then strict alternation.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h40, '0);
    n = 0; order = '0; gr = '0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        check("fair_single_ack", 64'(cpu_ack & dma_ack), 64'h0);
        if (dma_ack) check("fair_dma_rdata", 64'(dma_rdata), 64'h12345678);
        else         check("fair_cpu_rdata", 64'(cpu_rdata), 64'hA5A5A5A5);
        order[n] = dma_ack;
        gr[n]    = grant;
        at[n]    = c;
        n++;
        if (n == 4) begin
          drive(1'b0, 1'b0, 1'b0, '0, '0);
          drive(1'b1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check("fair_count", 64'(n), 64'd4);
    if (n == 4) begin
      check("fair_order", 64'(order), 64'b1010);
      check("fair_grant", 64'(gr), 64'b1010);
      check("fair_first_ack", 64'(at[0]), 64'd3);
      check("fair_spacing", 64'({8'(at[1] - at[0]), 8'(at[2] - at[1]), 8'(at[3] - at[2])}),
            64'h040404);
    end

    // CPU holds req through its ack with a new address: next grant in the IDLE cycle after DONE.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
    en_m = '0; ack_m = '0; n = 0; ack_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en_m[c]  = mem_en;
      ack_m[c] = cpu_ack;
      if (mem_en && n < 4) begin
        en_addr[n] = mem_addr;
        n++;
      end
      if (cpu_ack) begin
        ack_cyc++;
        if (ack_cyc == 1) begin
          check("b2b_rdata1", 64'(cpu_rdata), 64'hA5A5A5A5);
          drive(1'b0, 1'b1, 1'b0, 32'h20, '0);
        end else begin
          check("b2b_rdata2", 64'(cpu_rdata), 64'(init_val(32'h20)));
          drive(1'b0, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check("b2b_en_timing", 64'(en_m), 64'h0022);
    check("b2b_ack_timing", 64'(ack_m), 64'h0088);
    if (n >= 2) check("b2b_addr2", 64'(en_addr[1]), 64'h20);

    // LATENCY=3: ack at t0+5, data from exactly t0+4.
    @(negedge clk);
    b_req = 1'b1; b_addr = 32'h30;
    en_m = '0; ack_m = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      en_m[c]  = b_mem_en;
      ack_m[c] = b_ack;
      if (b_mem_en) check("l3_issue", 64'({b_mem_we, b_grant, b_mem_addr}), 64'h30);
      if (b_ack) begin
        check("l3_rdata", 64'(b_rdata), 64'hCAFEF00D);
        b_req = 1'b0;
      end
    end
    check("l3_en_timing", 64'(en_m), 64'h02);
    check("l3_ack_timing", 64'(ack_m), 64'h20);
    check("l3_dma_quiet", 64'({b_dack, b_drdata, b_mem_wdata}), 64'h0);

    // Reset during WAIT of a read: outputs clear at once, no ack, then a normal read.
    b_req = 1'b1; b_addr = 32'h34;
    repeat (3) @(negedge clk);
    check("l3_busy_in_wait", 64'(b_busy), 64'h1);
    b_reset = 1'b1;
    #1;
    check("l3_rst_ctrl", 64'({b_ack, b_dack, b_mem_en, b_mem_we, b_busy, b_grant}), 64'h0);
    check("l3_rst_bus", 64'({b_mem_addr, b_mem_wdata}), 64'h0);
    check("l3_rst_rdata", 64'({b_rdata, b_drdata}), 64'h0);
    b_req = 1'b0;
    @(negedge clk);
    b_reset = 1'b0;
    noack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      noack = noack | b_ack;
    end
    check("l3_no_ack_after_reset", 64'(noack), 64'h0);
    b_req = 1'b1; b_addr = 32'h38;
    ack_cyc = 0;
    for (int c = 1; c <= 8 && ack_cyc == 0; c++) begin
      @(negedge clk);
      if (b_ack) begin
        ack_cyc = c;
        check("l3_post_reset_rdata", 64'(b_rdata), 64'hCAFEF00D);
        b_req = 1'b0;
      end
    end
    check("l3_post_reset_ack", 64'(ack_cyc), 64'd5);
    b_req = 1'b0;

    // Randomized two-port traffic on addresses 0x80..0xFF against a transaction-level model.
    for (int i = 128; i < 256; i++) ref_mem[i] = init_val(i);
    last_rd[0] = init_val(32'h20);
    last_rd[1] = 32'h12345678;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; we_r[p] = 1'b0; a_r[p] = '0; d_r[p] = '0; age[p] = 0;
    end
    ntx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        ack_p = (p == 1) ? dma_ack : cpu_ack;
        rd_p  = (p == 1) ? dma_rdata : cpu_rdata;
        if (ack_p) begin
          check($sformatf("rnd_ack_pending_p%0d", p), 64'(pend[p]), 64'h1);
          if (pend[p]) begin
            if (we_r[p]) ref_mem[a_r[p][7:0]] = d_r[p];
            else         last_rd[p] = ref_mem[a_r[p][7:0]];
            check($sformatf("rnd_rdata_p%0d", p), 64'(rd_p), 64'(last_rd[p]));
            pend[p] = 1'b0;
            ntx++;
          end
        end else if (pend[p]) begin
          age[p]++;
          if (age[p] > 40) begin
            check($sformatf("rnd_timeout_p%0d", p), 64'(age[p]), 64'd40);
            pend[p] = 1'b0;
          end
        end
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          we_r[p] = 1'($urandom_range(0, 1));
          a_r[p]  = 32'h80 | 32'($urandom_range(0, 127));
          d_r[p]  = $urandom;
          age[p]  = 0;
        end
        drive(p == 1, pend[p], we_r[p], a_r[p], d_r[p]);
      end
    end
    check("rnd_progress", 64'(ntx >= 200), 64'h1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
